// File: rtl/servo_ramp_sequencer.sv
// servo_ramp_sequencer: once per PWM frame, walks channels 0..3 and slews each
// channel's commanded pulse toward its host-set target by at most its rate.
// It then issues a one-cycle cs write to the servo controller for every channel
// whose value changed. All four channels are written in the first frame after reset.
module servo_ramp_sequencer #(
  parameter int FULL_CYCLE = 20000,
  parameter int MIN_PULSE  = 500,
  parameter int MAX_PULSE  = 2500,
  parameter int INIT_PULSE = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_we,
  input  logic [1:0]  host_ch,
  input  logic [14:0] host_target,
  input  logic [14:0] host_rate,
  output logic        cs,
  output logic [1:0]  addr,
  output logic [14:0] data,
  output logic        busy,
  output logic [3:0]  done,
  output logic        frame_start
);

  localparam int FCW = $clog2(FULL_CYCLE);
  localparam logic [FCW-1:0] FC_LAST = FCW'(FULL_CYCLE - 1);
  localparam logic [14:0] MIN_P  = 15'(MIN_PULSE);
  localparam logic [14:0] MAX_P  = 15'(MAX_PULSE);
  localparam logic [14:0] INIT_P = 15'(INIT_PULSE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_WRITE   = 2'd2,
    S_NEXT    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     ch_q, ch_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [14:0]    cur_q [4];
  logic [14:0]    cur_d [4];
  logic [14:0]    tgt_q [4];
  logic [14:0]    tgt_d [4];
  logic [14:0]    rate_q [4];
  logic [14:0]    rate_d [4];
  logic [14:0]    nv_q, nv_d;
  logic           init_pending_q, init_pending_d;
  logic           cs_q, cs_d;
  logic [1:0]     addr_q, addr_d;
  logic [14:0]    data_q, data_d;
  logic           frame_start_q, frame_start_d;

  logic [14:0]    cur_sel_s, tgt_sel_s, rate_sel_s, step_val_s;
  logic [15:0]    diff_s, abs_diff_s;

  // Limit a requested pulse width to the legal servo range.
  function automatic logic [14:0] clamp_pulse(input logic [14:0] v);
    if (v < MIN_P) begin
      return MIN_P;
    end else if (v > MAX_P) begin
      return MAX_P;
    end else begin
      return v;
    end
  endfunction

  // One slew step for the selected channel; never overshoots the target.
  always_comb begin
    cur_sel_s  = cur_q[ch_q];
    tgt_sel_s  = tgt_q[ch_q];
    rate_sel_s = rate_q[ch_q];
    diff_s     = {1'b0, tgt_sel_s} - {1'b0, cur_sel_s};
    abs_diff_s = diff_s[15] ? (16'd0 - diff_s) : diff_s;
    step_val_s = tgt_sel_s;
    if ((rate_sel_s == 15'd0) || (abs_diff_s <= {1'b0, rate_sel_s})) begin
      step_val_s = tgt_sel_s;
    end else if (!diff_s[15]) begin
      step_val_s = cur_sel_s + rate_sel_s;
    end else begin
      step_val_s = cur_sel_s - rate_sel_s;
    end
  end

  // Frame counter, sequencer next state, host register updates.
  always_comb begin
    frame_cnt_d    = (frame_cnt_q == FC_LAST) ? '0 : frame_cnt_q + 1'b1;
    frame_start_d  = (frame_cnt_q == '0);
    state_d        = state_q;
    ch_d           = ch_q;
    nv_d           = nv_q;
    init_pending_d = init_pending_q;
    cs_d           = 1'b0;
    addr_d         = addr_q;
    data_d         = data_q;
    cur_d          = cur_q;
    tgt_d          = tgt_q;
    rate_d         = rate_q;

    case (state_q)
      S_IDLE: begin
        if (frame_cnt_q == '0) begin
          state_d = S_COMPUTE;
          ch_d    = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPUTE: begin
        nv_d    = step_val_s;
        state_d = S_WRITE;
        // Unchanged channels are skipped, except on the first frame after reset.
        if ((step_val_s != cur_sel_s) || init_pending_q) begin
          cs_d   = 1'b1;
          addr_d = ch_q;
          data_d = step_val_s;
        end else begin
          cs_d   = 1'b0;
        end
      end
      S_WRITE: begin
        cur_d[ch_q] = nv_q;
        state_d     = S_NEXT;
      end
      S_NEXT: begin
        if (ch_q == 2'd3) begin
          state_d        = S_IDLE;
          init_pending_d = 1'b0;
        end else begin
          ch_d    = ch_q + 2'd1;
          state_d = S_COMPUTE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // COMPUTE above reads the registered target/rate, so a write landing on
    // the same edge only takes effect next frame.
    if (host_we) begin
      tgt_d[host_ch]  = clamp_pulse(host_target);
      rate_d[host_ch] = host_rate;
    end else begin
      tgt_d  = tgt_d;
      rate_d = rate_d;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ch_q           <= 2'd0;
      frame_cnt_q    <= '0;
      nv_q           <= 15'd0;
      init_pending_q <= 1'b1;
      cs_q           <= 1'b0;
      addr_q         <= 2'd0;
      data_q         <= 15'd0;
      frame_start_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        cur_q[k]  <= INIT_P;
        tgt_q[k]  <= INIT_P;
        rate_q[k] <= 15'd0;
      end
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      frame_cnt_q    <= frame_cnt_d;
      nv_q           <= nv_d;
      init_pending_q <= init_pending_d;
      cs_q           <= cs_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      frame_start_q  <= frame_start_d;
      cur_q          <= cur_d;
      tgt_q          <= tgt_d;
      rate_q         <= rate_d;
    end
  end

  assign cs          = cs_q;
  assign addr        = addr_q;
  assign data        = data_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = {(cur_q[3] == tgt_q[3]), (cur_q[2] == tgt_q[2]),
                        (cur_q[1] == tgt_q[1]), (cur_q[0] == tgt_q[0])};

endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// Randomized bench for servo_ramp_sequencer.
// A frame-schedule reference model predicts every output after every clock edge.
module tb_servo_ramp_sequencer;

  localparam int FC = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_we = 1'b0;
  logic [1:0]  host_ch = 2'd0;
  logic [14:0] host_target = 15'd0;
  logic [14:0] host_rate = 15'd0;
  logic        cs;
  logic [1:0]  addr;
  logic [14:0] data;
  logic        busy;
  logic [3:0]  done;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int m_cur [4];
  int m_tgt [4];
  int m_rate [4];
  int m_nv;
  bit m_init;
  int m_e;
  int e_cs, e_addr, e_data, e_busy, e_fs;

  servo_ramp_sequencer #(.FULL_CYCLE(FC)) dut (
    .clk(clk), .rst(rst), .host_we(host_we), .host_ch(host_ch),
    .host_target(host_target), .host_rate(host_rate),
    .cs(cs), .addr(addr), .data(data), .busy(busy), .done(done),
    .frame_start(frame_start)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, m_e);
    end
  endtask

  function automatic int clamp_i(input int v);
    if (v < 500) return 500;
    if (v > 2500) return 2500;
    return v;
  endfunction

  function automatic int slew(input int c, input int t, input int r);
    int d;
    d = (t > c) ? t - c : c - t;
    if (r == 0 || d <= r) return t;
    return (t > c) ? c + r : c - r;
  endfunction

  // Apply one clock edge to the model: channel k is computed at frame offset
  // 3k+1 and its position updated at 3k+2; the sequence spans offsets 0..11.
  task automatic model_edge();
    int o, k;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_cur[i] = 1500; m_tgt[i] = 1500; m_rate[i] = 0;
      end
      m_init = 1'b1; m_e = 0;
      e_cs = 0; e_addr = 0; e_data = 0; e_busy = 0; e_fs = 0;
    end else begin
      o = m_e % FC;
      e_cs = 0;
      e_fs = (o == 0) ? 1 : 0;
      e_busy = (o <= 11) ? 1 : 0;
      if (o <= 10 && (o % 3) == 1) begin
        k = o / 3;
        m_nv = slew(m_cur[k], m_tgt[k], m_rate[k]);
        if (m_nv != m_cur[k] || m_init) begin
          e_cs = 1; e_addr = k; e_data = m_nv;
        end
      end
      if (o <= 11 && (o % 3) == 2) m_cur[o / 3] = m_nv;
      if (o == 12) m_init = 1'b0;
      if (host_we) begin
        m_tgt[host_ch] = clamp_i(int'(host_target));
        m_rate[host_ch] = int'(host_rate);
      end
      m_e++;
    end
  endtask

  task automatic tick();
    int e_done;
    @(posedge clk);
    model_edge();
    #1;
    e_done = 0;
    for (int i = 0; i < 4; i++) if (m_cur[i] == m_tgt[i]) e_done |= (1 << i);
    check_val("cs", cs, e_cs);
    check_val("addr", addr, e_addr);
    check_val("data", data, e_data);
    check_val("busy", busy, e_busy);
    check_val("frame_start", frame_start, e_fs);
    check_val("done", done, e_done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic host_write(input int ch, input int tgt, input int rate);
    host_we = 1'b1; host_ch = 2'(ch); host_target = 15'(tgt); host_rate = 15'(rate);
    tick();
    host_we = 1'b0;
  endtask

  // Advance until the next edge lands on frame offset off (bounded by one frame).
  task automatic wait_offset(input int off);
    for (int i = 0; i < FC && (m_e % FC) != off; i++) tick();
  endtask

  initial begin
    int r;
    // Reset for a few cycles, then the init frame writes 1500 to every channel.
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(2 * FC);

    // Ramp ch0 to 2000 in 100 steps.
    host_write(0, 2000, 100);
    run(7 * FC);

    // Clamped jumps.
    host_write(2, 3000, 0);
    host_write(1, 100, 0);
    run(2 * FC);

    // Small move that must not overshoot.
    host_write(3, 1550, 100);
    run(2 * FC);

    // Host write coinciding with ch1 COMPUTE.
    wait_offset(4);
    host_write(1, 700, 0);
    run(2 * FC);

    // Reset during ch2 WRITE, then a fresh init frame.
    host_write(0, 900, 30);
    wait_offset(8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(2 * FC);

    // Randomized host traffic with occasional resets.
    for (int i = 0; i < 1600; i++) begin
      host_we = ($urandom_range(0, 7) == 0);
      host_ch = 2'($urandom_range(0, 3));
      host_target = ($urandom_range(0, 9) == 0) ? 15'($urandom) : 15'($urandom_range(0, 3200));
      r = $urandom_range(0, 3);
      case (r)
        0: host_rate = 15'd0;
        1: host_rate = 15'($urandom_range(1, 50));
        2: host_rate = 15'($urandom_range(51, 400));
        default: host_rate = 15'($urandom);
      endcase
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    host_we = 1'b0;
    rst = 1'b0;
    run(2 * FC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/servo_ramp_sequencer.md
Name: servo_ramp_sequencer

Overview:
Per-channel motion scheduler that sits between a host register interface and the 4-channel servo PWM controller (cs/addr/data write port, 15-bit compare values, 20,000-cycle frame).
- Host sets a target pulse width and a slew rate per channel.
- Once per PWM frame, the block walks channels 0..3 and moves each channel's commanded pulse toward its target by at most its rate.
- Each changed value is written into the servo controller as a one-cycle cs write.

Parameters:
FULL_CYCLE, 20000, frame length in clocks; must be >= 16
MIN_PULSE, 500, lowest legal compare value
MAX_PULSE, 2500, highest legal compare value
INIT_PULSE, 1500, position after reset

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
host_we  input  1  write strobe for target/rate of host_ch
host_ch  input  2  channel selected by host write
host_target  input  15  requested pulse width
host_rate  input  15  max change per frame; 0 = jump immediately
cs  output  1  servo controller chip select, one-cycle write pulse
addr  output  2  servo channel being written
data  output  15  compare value being written
busy  output  1  sequencer not IDLE
done  output  4  done[k]=1 when current[k]==target[k]
frame_start  output  1  one-cycle pulse on the edge where frame_cnt leaves 0

Behaviour:
- Single clock domain. All registers reset synchronously on rst=1. Sync reset is active-high.
- Reset values:
  - cs=0, addr=0, data=0, busy=0, frame_start=0.
  - frame_cnt=0; state=IDLE; ch=0.
  - current[k]=target[k]=INIT_PULSE; rate[k]=0; done=4'hF.
  - init_pending=1.
- Reset mid-sequence aborts the sequence. cs is low in the cycle after the reset edge, and all state returns to reset values.
- frame_cnt counts 0..FULL_CYCLE-1 and wraps to 0.
- Host write (host_we=1, rst=0):
  - target[host_ch] <= clamp(host_target, MIN_PULSE, MAX_PULSE).
  - rate[host_ch] <= host_rate.
  - Takes effect at the next edge.
  - If it coincides with COMPUTE for the same channel, COMPUTE uses the old target/rate; the new value applies next frame.
- FSM states: IDLE, COMPUTE, WRITE, NEXT. Every channel costs exactly 3 cycles, so a full sequence is 12 cycles.
  - IDLE: at the edge where frame_cnt==0 (edge F), go to COMPUTE, set ch=0, pulse frame_start.
  - COMPUTE: compute next_val as follows.
    - diff = target - current, 16-bit signed.
    - If rate==0 or |diff|<=rate, next_val = target.
    - Else next_val = current + rate when diff>0, or current - rate when diff<0.
    - Go to WRITE.
    - Register cs=1, addr=ch, data=next_val only if next_val!=current or init_pending. Otherwise cs stays 0.
  - WRITE: current[ch] <= next_val; cs <= 0; go to NEXT.
  - NEXT: if ch==3, go to IDLE and clear init_pending; else ch+1 and go to COMPUTE.
- Timing: channel k cs is high for exactly one clock, between edges F+3k+1 and F+3k+2.
- addr and data hold their last written values when cs=0.
- busy = (state != IDLE).
- done is combinational from current/target.
- After reset, the first frame writes INIT_PULSE to all four channels: the init_pending write occurs even though current==target.
- Arithmetic never leaves [MIN_PULSE, MAX_PULSE]: targets are clamped and steps never overshoot the target.
- rate values larger than the span are legal and behave as a jump.

Test Plan:
- Reset, run 20 cycles -> four cs pulses at edges F+1, F+4, F+7, F+10, with addr=0..3 and data=1500 each. busy is high for 12 cycles, then low; done=4'hF.
- Next frame with no host writes -> zero cs pulses for the whole frame; frame_start pulses once every 20000 cycles.
- host write ch0 target=2000 rate=100 -> on each subsequent frame ch0 writes data 1600, 1700, 1800, 1900, 2000, then no further writes. done[0]=0 until the 2000 write completes, then 1.
- host write ch2 target=3000 rate=0 -> target clamped to 2500; the next frame writes addr=2 data=2500 in a single step. ch1 target=100 -> clamped to 500.
- Target 1550 rate=100 from 1500 -> exactly one write of 1550 (no overshoot). Host write to ch1 in the same cycle as ch1 COMPUTE -> old target used this frame, new target applied next frame.
- Assert rst during WRITE of ch2 -> cs=0 after the reset edge, current restored to 1500. The next frame writes all four channels with 1500 again.
